// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: state encoding and
// the counter width helper.
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    function automatic int CNT_W(input int max_width);
        return $clog2(max_width);
    endfunction

endpackage

// File: rtl/mult_ctrl_fsm.sv
// Control FSM for the shift-and-add multiplier: sequences load, MAX_WIDTH
// step cycles and a single done cycle, and decodes the status outputs.
module mult_ctrl_fsm
    import mult_pkg::*;
#(
    parameter int MAX_WIDTH = 8
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   start,
    input  logic   abort,
    output logic   load,
    output logic   step,
    output logic   finish,
    output logic   done,
    output logic   busy,
    output state_t state
);

    localparam int CW = CNT_W(MAX_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(MAX_WIDTH - 1);

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!abort && start) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // abort drops the operation without touching the datapath
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    step  = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        finish  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign done  = (state_q == ST_DONE);
    assign busy  = (state_q != ST_IDLE);
    assign state = state_q;

endmodule

// File: rtl/shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier: one partial product per
// cycle, result registered on the last step and flagged by a one-cycle done.
module shift_add_mult
    import mult_pkg::*;
#(
    parameter int MAX_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [MAX_WIDTH-1:0]   a,
    input  logic [MAX_WIDTH-1:0]   b,
    output logic [2*MAX_WIDTH-1:0] product,
    output logic                   done,
    output logic                   busy
);

    // Handshake: start is a request taken only while busy is low (a and b are
    // captured on that edge); every accepted request that is not aborted ends
    // with exactly one done cycle, during which product already holds a*b.

    localparam int PW = 2 * MAX_WIDTH;

    logic          load;
    logic          step;
    logic          finish;
    state_t        fsm_state;
    logic [PW-1:0] mcand;
    logic [PW-1:0] acc;
    logic [PW-1:0] addend;
    logic [PW-1:0] sum;
    logic [MAX_WIDTH-1:0] mplier;

    mult_ctrl_fsm #(
        .MAX_WIDTH(MAX_WIDTH)
    ) u_ctrl (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .abort (abort),
        .load  (load),
        .step  (step),
        .finish(finish),
        .done  (done),
        .busy  (busy),
        .state (fsm_state)
    );

    assign addend = mplier[0] ? mcand : '0;
    assign sum    = acc + addend;

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            product <= '0;
        end else if (load) begin
            mcand  <= {{MAX_WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
        end else if (step) begin
            acc    <= sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            // sum already includes this edge's partial product
            if (finish) begin
                product <= sum;
            end
        end
    end

    illegal_state_never : assert property (@(posedge clk) disable iff (rst)
        2'(fsm_state) != 2'b11);

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed bench for shift_add_mult at MAX_WIDTH=8 and MAX_WIDTH=4.
module tb_shift_add_mult;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start8 = 1'b0;
    logic        abort8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic [15:0] product8;
    logic        done8;
    logic        busy8;

    logic        start4 = 1'b0;
    logic        abort4 = 1'b0;
    logic [3:0]  a4 = '0;
    logic [3:0]  b4 = '0;
    logic [7:0]  product4;
    logic        done4;
    logic        busy4;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] exp_q[$];

    shift_add_mult #(.MAX_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .abort(abort8),
        .a(a8), .b(b8), .product(product8), .done(done8), .busy(busy8)
    );

    shift_add_mult #(.MAX_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .abort(abort4),
        .a(a4), .b(b4), .product(product4), .done(done4), .busy(busy4)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    function automatic logic cur_done(input bit w4);
        return w4 ? done4 : done8;
    endfunction

    function automatic logic cur_busy(input bit w4);
        return w4 ? busy4 : busy8;
    endfunction

    function automatic logic [15:0] cur_prod(input bit w4);
        return w4 ? {8'h00, product4} : product8;
    endfunction

    // Driver: issue one start, scramble operands mid-run, check latency,
    // busy, product and the single-cycle done.
    task automatic mul(input bit w4, input logic [7:0] x, input logic [7:0] y,
                       input logic [15:0] exp, input string tag);
        int n;
        bit busy_ok;
        int lat;
        lat = w4 ? 4 : 8;
        if (w4) begin
            a4 = x[3:0]; b4 = y[3:0]; start4 = 1'b1;
        end else begin
            a8 = x; b8 = y; start8 = 1'b1;
        end
        @(negedge clk);
        start4 = 1'b0;
        start8 = 1'b0;
        a8 = 8'($urandom_range(0, 255));
        b8 = 8'($urandom_range(0, 255));
        a4 = 4'($urandom_range(0, 15));
        b4 = 4'($urandom_range(0, 15));
        check({tag, "_busy_start"}, 64'(cur_busy(w4)), 64'(1));
        n = 0;
        busy_ok = 1'b1;
        while (!cur_done(w4) && n < 20) begin
            @(negedge clk);
            n++;
            if (!cur_busy(w4)) busy_ok = 1'b0;
        end
        check({tag, "_latency"}, 64'(n), 64'(lat));
        check({tag, "_busy_run"}, 64'(busy_ok), 64'(1));
        check({tag, "_product"}, 64'(cur_prod(w4)), 64'(exp));
        @(negedge clk);
        check({tag, "_done_clear"}, 64'(cur_done(w4)), 64'(0));
        check({tag, "_idle"}, 64'(cur_busy(w4)), 64'(0));
        check({tag, "_held"}, 64'(cur_prod(w4)), 64'(exp));
    endtask

    logic [7:0] pa[3] = '{8'd20, 8'd255, 8'd128};
    logic [7:0] pb[3] = '{8'd30, 8'd1,   8'd2};
    logic [15:0] pe[3] = '{16'h0258, 16'h00FF, 16'h0100};

    initial begin
        int idx;
        int seen;
        int cyc;
        int last;
        int dcount;
        bit prev_busy;
        logic [7:0] x;
        logic [7:0] y;

        // reset
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_product8", 64'(product8), 64'(0));
        check("rst_done8", 64'(done8), 64'(0));
        check("rst_busy8", 64'(busy8), 64'(0));
        check("rst_product4", 64'(product4), 64'(0));
        check("rst_busy4", 64'(busy4), 64'(0));
        @(negedge clk);

        mul(1'b0, 8'd13, 8'd11, 16'h008F, "m13x11");
        mul(1'b0, 8'd255, 8'd255, 16'hFE01, "m255x255");
        mul(1'b0, 8'd0, 8'd200, 16'h0000, "m0x200");

        // start held high: three results, 10 cycles apart
        idx = 0; seen = 0; cyc = 0; last = -1; prev_busy = 1'b0;
        a8 = pa[0]; b8 = pb[0]; exp_q.push_back(pe[0]);
        start8 = 1'b1;
        for (int t = 0; t < 60 && seen < 3; t++) begin
            @(negedge clk);
            cyc++;
            if (busy8 && !prev_busy) begin
                idx++;
                if (idx < 3) begin
                    a8 = pa[idx]; b8 = pb[idx]; exp_q.push_back(pe[idx]);
                end else begin
                    start8 = 1'b0;
                end
            end
            if (done8) begin
                if (exp_q.size() > 0) check("b2b_product", 64'(product8), 64'(exp_q.pop_front()));
                else check("b2b_extra_done", 64'(1), 64'(0));
                if (last >= 0) check("b2b_gap", 64'(cyc - last), 64'(10));
                last = cyc;
                seen++;
            end
            prev_busy = busy8;
        end
        start8 = 1'b0;
        check("b2b_count", 64'(seen), 64'(3));
        repeat (3) @(negedge clk);

        // abort at the 4th RUN edge
        mul(1'b0, 8'd13, 8'd11, 16'h008F, "m13x11_pre_abort");
        a8 = 8'd6; b8 = 8'd7; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        abort8 = 1'b1;
        @(negedge clk);
        abort8 = 1'b0;
        check("abort_busy", 64'(busy8), 64'(0));
        check("abort_done", 64'(done8), 64'(0));
        check("abort_product", 64'(product8), 64'(143));
        dcount = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) dcount++;
        end
        check("abort_no_done", 64'(dcount), 64'(0));
        mul(1'b0, 8'd6, 8'd7, 16'd42, "m6x7");

        // reset mid-run
        a8 = 8'd9; b8 = 8'd9; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_run_product", 64'(product8), 64'(0));
        check("rst_run_busy", 64'(busy8), 64'(0));
        check("rst_run_done", 64'(done8), 64'(0));

        // start with abort in IDLE loads nothing
        a8 = 8'd5; b8 = 8'd5; start8 = 1'b1; abort8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; abort8 = 1'b0;
        check("start_abort_busy", 64'(busy8), 64'(0));
        @(negedge clk);
        check("start_abort_busy2", 64'(busy8), 64'(0));
        check("start_abort_product", 64'(product8), 64'(0));

        // MAX_WIDTH=4
        mul(1'b1, 8'd15, 8'd15, 16'h00E1, "w4_15x15");
        mul(1'b1, 8'd0, 8'd9, 16'h0000, "w4_0x9");

        // random pairs
        for (int i = 0; i < 6; i++) begin
            x = 8'($urandom_range(0, 255));
            y = 8'($urandom_range(0, 255));
            mul(1'b0, x, y, 16'(x) * 16'(y), "rand8");
        end
        for (int i = 0; i < 6; i++) begin
            x = 8'($urandom_range(0, 15));
            y = 8'($urandom_range(0, 15));
            mul(1'b1, x, y, 16'(x) * 16'(y), "rand4");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
